// File: rtl/sr_fixed_pkg.sv
// Shared fixed-point formats for the Q3.12 -> Q7.24 dequantizer slice: widths,
// LFSR constants, skid-buffer state type and the narrow-to-wide conversion.
package sr_fixed_pkg;

    localparam int Q_NARROW_W    = 16;
    localparam int Q_NARROW_FRAC = 12;
    localparam int Q_WIDE_W      = 32;
    localparam int Q_WIDE_FRAC   = 24;
    localparam int FILL_W        = Q_WIDE_FRAC - Q_NARROW_FRAC;

    localparam logic [15:0] LFSR_SEED = 16'h9FC7;
    // x^16 + x^14 + x^13 + x^11 + 1 in right-shift Galois form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    function automatic logic [Q_WIDE_W-1:0] widen_q(
        input logic [Q_NARROW_W-1:0] x,
        input logic [FILL_W-1:0]     fill
    );
        return {{(Q_WIDE_W - Q_NARROW_W - FILL_W){x[Q_NARROW_W-1]}}, x, fill};
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/sr_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer; all outputs come straight from
// registers, so there is no combinational path from m_ready to s_ready.
module sr_skid_buffer
    import sr_fixed_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);

    buf_state_e   state_r;
    logic [W-1:0] main_r;
    logic [W-1:0] skid_r;
    logic         m_valid_r;
    logic         s_ready_r;
    logic         accept_s;
    logic         take_s;

    assign accept_s = s_valid & s_ready_r;
    assign take_s   = m_valid_r & m_ready;
    assign s_ready  = s_ready_r;
    assign m_valid  = m_valid_r;
    assign m_data   = main_r;

    // Buffer occupancy FSM with its registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= BUF_EMPTY;
            main_r    <= {W{1'b0}};
            skid_r    <= {W{1'b0}};
            m_valid_r <= 1'b0;
            s_ready_r <= 1'b1;
        end else begin
            case (state_r)
                BUF_EMPTY: begin
                    if (accept_s) begin
                        main_r    <= s_data;
                        m_valid_r <= 1'b1;
                        state_r   <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (accept_s && take_s) begin
                        main_r <= s_data;
                    end else if (accept_s) begin
                        skid_r    <= s_data;
                        s_ready_r <= 1'b0;
                        state_r   <= BUF_FULL;
                    end else if (take_s) begin
                        m_valid_r <= 1'b0;
                        state_r   <= BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (take_s) begin
                        main_r    <= skid_r;
                        s_ready_r <= 1'b1;
                        state_r   <= BUF_ONE;
                    end
                end
                default: begin
                    m_valid_r <= 1'b0;
                    s_ready_r <= 1'b1;
                    state_r   <= BUF_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/sr_dequant_stream.sv
// Widens Q3.12 samples to Q7.24 behind a skid buffer and keeps per-frame sums.
// Define SR_DEQUANT_DITHER_EN to fill the new fraction bits from an LFSR.
module sr_dequant_stream
    import sr_fixed_pkg::*;
#(
    parameter int FRAME_LEN = 256,
    parameter int ACC_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [Q_NARROW_W-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [Q_WIDE_W-1:0]   m_data,
    input  logic                  stat_clear,
    output logic                  stat_valid,
    output logic [ACC_W-1:0]      stat_sum
);

    localparam int               CNT_W    = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    logic                  accept_s;
    logic                  take_s;
    logic [FILL_W-1:0]     fill_s;
    logic [Q_WIDE_W-1:0]   wide_s;
    logic [Q_NARROW_W-1:0] sample_s;
    logic [ACC_W-1:0]      sext_s;
    logic [ACC_W-1:0]      acc_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  stat_valid_r;
    logic [ACC_W-1:0]      stat_sum_r;

    assign accept_s = s_valid & s_ready;
    assign take_s   = m_valid & m_ready;

`ifdef SR_DEQUANT_DITHER_EN
    logic [15:0] lfsr_r;

    // Dither source steps once per accepted sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= LFSR_SEED;
        end else if (accept_s) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    assign fill_s = lfsr_r[FILL_W-1:0];
`else
    assign fill_s = {FILL_W{1'b0}};
`endif

    assign wide_s = widen_q(s_data, fill_s);

    sr_skid_buffer #(
        .W (Q_WIDE_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (wide_s),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    // The original undithered sample sits intact in the middle of the wide word
    assign sample_s = m_data[FILL_W +: Q_NARROW_W];
    assign sext_s   = {{(ACC_W - Q_NARROW_W){sample_s[Q_NARROW_W-1]}}, sample_s};

    // Frame accumulator; a clear beats a coincident frame end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r        <= {ACC_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            stat_valid_r <= 1'b0;
            stat_sum_r   <= {ACC_W{1'b0}};
        end else if (stat_clear) begin
            acc_r        <= {ACC_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            stat_valid_r <= 1'b0;
        end else if (take_s && (cnt_r == LAST_CNT)) begin
            stat_sum_r   <= acc_r + sext_s;
            stat_valid_r <= 1'b1;
            acc_r        <= {ACC_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
        end else if (take_s) begin
            acc_r        <= acc_r + sext_s;
            cnt_r        <= cnt_r + CNT_W'(1);
            stat_valid_r <= 1'b0;
        end else begin
            stat_valid_r <= 1'b0;
        end
    end

    assign stat_valid = stat_valid_r;
    assign stat_sum   = stat_sum_r;

endmodule

// File: tb/tb_sr_dequant_stream.sv
// Directed bench for sr_dequant_stream with FRAME_LEN=4; with SR_DEQUANT_DITHER_EN
// defined it also checks the dither fill and masks fill bits elsewhere.
module tb_sr_dequant_stream;

`ifdef SR_DEQUANT_DITHER_EN
    localparam logic [31:0] MASK  = 32'hFFFFF000;
    localparam logic [31:0] FILL0 = 32'h00000FC7;
    localparam logic [31:0] FILL1 = 32'h00000BE3;
`else
    localparam logic [31:0] MASK  = 32'hFFFFFFFF;
    localparam logic [31:0] FILL0 = 32'h00000000;
    localparam logic [31:0] FILL1 = 32'h00000000;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        stat_clear;
    logic        stat_valid;
    logic [31:0] stat_sum;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    sr_dequant_stream #(
        .FRAME_LEN (4),
        .ACC_W     (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .stat_clear (stat_clear),
        .stat_valid (stat_valid),
        .stat_sum   (stat_sum)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [31:0] exp);
        chk(tag, m_data & MASK, exp & MASK);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Four back-to-back samples with m_ready=1, then one drain cycle
    task automatic send_frame(input logic [15:0] a, input logic [15:0] last, input logic clr);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = (i == 3) ? last : a;
            step();
            chk("no_pulse_mid_frame", {31'd0, stat_valid}, 32'd0);
        end
        s_valid    = 1'b0;
        stat_clear = clr;
        step();
        stat_clear = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        s_valid    = 1'b0;
        s_data     = 16'h0000;
        m_ready    = 1'b0;
        stat_clear = 1'b0;
        step();
        step();
        chk("rst_s_ready",    {31'd0, s_ready},    32'd1);
        chk("rst_m_valid",    {31'd0, m_valid},    32'd0);
        chk("rst_m_data",     m_data,              32'd0);
        chk("rst_stat_valid", {31'd0, stat_valid}, 32'd0);
        chk("rst_stat_sum",   stat_sum,            32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Conversion with m_ready held high
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'h1800;
        step();
        chk("conv_valid", {31'd0, m_valid}, 32'd1);
        chkd("conv_1p5", 32'h01800000);
        s_data = 16'hF000;
        step();
        chkd("conv_m1", 32'hFF000000);
        s_valid = 1'b0;
        step();
        chk("conv_drain", {31'd0, m_valid}, 32'd0);
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;

        // Backpressure: two accepts fill the buffer
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h0001;
        step();
        chk("bp_ready_one", {31'd0, s_ready}, 32'd1);
        s_data = 16'h0002;
        step();
        chk("bp_ready_full", {31'd0, s_ready}, 32'd0);
        s_data = 16'h0003;
        step();
        chkd("bp_stable", 32'h00001000);
        m_ready = 1'b1;
        step();
        chkd("bp_out2", 32'h00002000);
        chk("bp_ready_back", {31'd0, s_ready}, 32'd1);
        step();
        chkd("bp_out3", 32'h00003000);
        s_valid = 1'b0;
        step();
        chk("bp_drain", {31'd0, m_valid}, 32'd0);
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;

        // Frame sum: 3*1.0 - 1.0 = 2.0 = 0x2000 LSBs
        send_frame(16'h1000, 16'hF000, 1'b0);
        chk("frame_pulse", {31'd0, stat_valid}, 32'd1);
        chk("frame_sum",   stat_sum,            32'h00002000);
        step();
        chk("frame_pulse_end", {31'd0, stat_valid}, 32'd0);
        chk("frame_sum_hold",  stat_sum,            32'h00002000);

        // Clear coinciding with the final take suppresses the frame
        send_frame(16'h0005, 16'h0005, 1'b1);
        chk("clr_no_pulse", {31'd0, stat_valid}, 32'd0);
        chk("clr_sum_hold", stat_sum,            32'h00002000);
        send_frame(16'h0001, 16'h0001, 1'b0);
        chk("clr_next_pulse", {31'd0, stat_valid}, 32'd1);
        chk("clr_next_sum",   stat_sum,            32'h00000004);

        // Reset asserted with the buffer full
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h0007;
        step();
        step();
        chk("mid_full", {31'd0, s_ready}, 32'd0);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("mid_rst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("mid_rst_sum",     stat_sum,         32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'h0000;
        step();
        chk("post_rst_valid", {31'd0, m_valid}, 32'd1);
        chk("post_rst_data0", m_data, FILL0);
        step();
        chk("post_rst_data1", m_data, FILL1);
        s_valid = 1'b0;
        step();
        chk("post_rst_drain", {31'd0, m_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
